// File: rtl/lab3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab3_pkg
// Brief    : Shared keypad geometry, scan-state encoding and helpers for the
//            lab 3 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package lab3_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_ROWS-1:0] ROW_INIT = 4'b0001;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_e;

    function automatic logic is_onehot(input logic [NUM_COLS-1:0] v);
        return ($countones(v) == 1);
    endfunction

    function automatic logic [NUM_ROWS-1:0] next_row(input logic [NUM_ROWS-1:0] r);
        return {r[NUM_ROWS-2:0], r[NUM_ROWS-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lab3_sync.sv
`default_nettype none
// ============================================================================
// Module   : lab3_sync
// Brief    : Parameterized-width two-flop synchronizer for asynchronous inputs.
// Revision : 1.0 - initial release
// ============================================================================
module lab3_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta_q;
    logic [WIDTH-1:0] r_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta_q <= '0;
            r_sync_q <= '0;
        end else begin
            r_meta_q <= d_i;
            r_sync_q <= r_meta_q;
        end
    end

    assign q_o = r_sync_q;

endmodule
`default_nettype wire

// File: rtl/lab3_keyscan.sv
`default_nettype none
// ============================================================================
// Module   : lab3_keyscan
// Brief    : 4x4 keypad row scanner with single-key debounce, held key code
//            and one-cycle press pulse. Optional macro KEYSCAN_AUTOREPEAT_EN
//            adds a key_new repeat every REPEAT_DIV ticks while held.
// Revision : 1.0 - initial release
// ============================================================================
module lab3_keyscan
    import lab3_pkg::*;
#(
    parameter int SCAN_DIV     = 4096,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_DIV   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] cols,
    output logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] key_cols,
    output logic [NUM_ROWS-1:0] key_rows,
    output logic                key_valid,
    output logic                key_new
);

    localparam int c_DIV_W = $clog2(SCAN_DIV);
    localparam int c_CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CNT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_SCAN     = SCAN;
    localparam logic [1:0] c_ST_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] c_ST_HELD     = HELD;

    logic [NUM_COLS-1:0] w_scols;

    logic [1:0]          r_state_q,     w_state_d;
    logic [NUM_ROWS-1:0] r_rows_q,      w_rows_d;
    logic [c_DIV_W-1:0]  r_div_q,       w_div_d;
    logic [c_CNT_W-1:0]  r_cnt_q,       w_cnt_d;
    logic [NUM_COLS-1:0] r_cap_cols_q,  w_cap_cols_d;
    logic [NUM_ROWS-1:0] r_cap_rows_q,  w_cap_rows_d;
    logic [NUM_COLS-1:0] r_key_cols_q,  w_key_cols_d;
    logic [NUM_ROWS-1:0] r_key_rows_q,  w_key_rows_d;
    logic                r_key_valid_q, w_key_valid_d;
    logic                r_key_new_q,   w_key_new_d;

    logic                w_tick;
    logic                w_held_bit;
    logic                w_repeat;
    logic [c_CNT_W-1:0]  w_cnt_inc;

    lab3_sync #(
        .WIDTH (NUM_COLS)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (cols),
        .q_o   (w_scols)
    );

    assign w_tick     = (r_div_q == c_DIV_LAST);
    assign w_div_d    = w_tick ? '0 : r_div_q + c_DIV_ONE;
    assign w_held_bit = |(w_scols & r_cap_cols_q);
    // Saturating so a held count can never wrap back below the threshold
    assign w_cnt_inc  = (r_cnt_q == c_CNT_MAX) ? r_cnt_q : r_cnt_q + c_CNT_ONE;

`ifdef KEYSCAN_AUTOREPEAT_EN
    localparam int c_REP_W = $clog2(REPEAT_DIV + 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_DIV - 1);
    localparam logic [c_REP_W-1:0] c_REP_ONE  = c_REP_W'(1);

    logic [c_REP_W-1:0] r_rep_q, w_rep_d;

    always_comb begin
        w_rep_d  = r_rep_q;
        w_repeat = 1'b0;
        if ((r_state_q != c_ST_HELD) || !w_held_bit) begin
            w_rep_d = '0;
        end else if (w_tick) begin
            if (r_rep_q == c_REP_LAST) begin
                w_rep_d  = '0;
                w_repeat = 1'b1;
            end else begin
                w_rep_d = r_rep_q + c_REP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_q <= '0;
        end else begin
            r_rep_q <= w_rep_d;
        end
    end
`else
    // Repeat rate is meaningless without autorepeat; both arms tie it off
    if (REPEAT_DIV > 0) begin : g_no_repeat
        assign w_repeat = 1'b0;
    end else begin : g_no_repeat_zero
        assign w_repeat = 1'b0;
    end
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_rows_d      = r_rows_q;
        w_cnt_d       = r_cnt_q;
        w_cap_cols_d  = r_cap_cols_q;
        w_cap_rows_d  = r_cap_rows_q;
        w_key_cols_d  = r_key_cols_q;
        w_key_rows_d  = r_key_rows_q;
        w_key_valid_d = r_key_valid_q;
        w_key_new_d   = w_repeat;
        if (w_tick) begin
            case (r_state_q)
                c_ST_SCAN: begin
                    if (is_onehot(w_scols)) begin
                        w_cap_cols_d = w_scols;
                        w_cap_rows_d = r_rows_q;
                        w_cnt_d      = c_CNT_ONE;
                        w_state_d    = c_ST_DEBOUNCE;
                    end else begin
                        w_rows_d = next_row(r_rows_q);
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (w_scols == r_cap_cols_q) begin
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_CNT_MAX) begin
                            w_cnt_d       = '0;
                            w_state_d     = c_ST_HELD;
                            w_key_valid_d = 1'b1;
                            w_key_cols_d  = r_cap_cols_q;
                            w_key_rows_d  = r_cap_rows_q;
                            w_key_new_d   = 1'b1;
                        end
                    end else begin
                        w_cnt_d   = '0;
                        w_state_d = c_ST_SCAN;
                        w_rows_d  = next_row(r_rows_q);
                    end
                end
                c_ST_HELD: begin
                    // Other keys in the captured row are ignored; only the captured bit counts
                    if (!w_held_bit) begin
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_CNT_MAX) begin
                            w_cnt_d       = '0;
                            w_state_d     = c_ST_SCAN;
                            w_rows_d      = next_row(r_rows_q);
                            w_key_valid_d = 1'b0;
                            w_key_cols_d  = '0;
                            w_key_rows_d  = '0;
                        end
                    end else begin
                        w_cnt_d = '0;
                    end
                end
                default: begin
                    w_state_d = c_ST_SCAN;
                    w_rows_d  = ROW_INIT;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= c_ST_SCAN;
            r_rows_q      <= ROW_INIT;
            r_div_q       <= '0;
            r_cnt_q       <= '0;
            r_cap_cols_q  <= '0;
            r_cap_rows_q  <= '0;
            r_key_cols_q  <= '0;
            r_key_rows_q  <= '0;
            r_key_valid_q <= 1'b0;
            r_key_new_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_rows_q      <= w_rows_d;
            r_div_q       <= w_div_d;
            r_cnt_q       <= w_cnt_d;
            r_cap_cols_q  <= w_cap_cols_d;
            r_cap_rows_q  <= w_cap_rows_d;
            r_key_cols_q  <= w_key_cols_d;
            r_key_rows_q  <= w_key_rows_d;
            r_key_valid_q <= w_key_valid_d;
            r_key_new_q   <= w_key_new_d;
        end
    end

    assign rows      = r_rows_q;
    assign key_cols  = r_key_cols_q;
    assign key_rows  = r_key_rows_q;
    assign key_valid = r_key_valid_q;
    assign key_new   = r_key_new_q;

endmodule
`default_nettype wire

// File: tb/tb_lab3_keyscan.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab3_keyscan
// Brief    : Self-checking bench for lab3_keyscan with a keypad model, a
//            key-event scoreboard and a table of press vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab3_keyscan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int REPEAT_DIV   = 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] c;
    } key_t;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        bit         accept;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_cols;
    logic [3:0] key_rows;
    logic       key_valid;
    logic       key_new;

    logic [3:0] kp_row;
    logic [3:0] kp_col;
    logic       kp_down;

    int   checks     = 0;
    int   passed     = 0;
    int   ecnt       = 0;
    int   last_new   = 0;
    logic prev_valid = 1'b0;
    key_t exp_q[$];
    key_t mon_k;
    logic [3:0] row_seq [4];
    vec_t vecs [6];

    always #5 clk = ~clk;

    // Keypad: a pressed key drives its column only while its row is strobed
    assign cols = (kp_down && ((rows & kp_row) != 4'b0000)) ? kp_col : 4'b0000;

    lab3_keyscan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_DIV   (REPEAT_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_cols  (key_cols),
        .key_rows  (key_rows),
        .key_valid (key_valid),
        .key_new   (key_new)
    );

    // Edges since reset release; the divider ticks on every edge where this becomes a multiple of SCAN_DIV
    always @(posedge clk) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, ecnt);
    endtask

    task automatic wait_row_start(input logic [3:0] r, input string name);
        int k = 0;
        while (rows === r && k < 64) begin @(negedge clk); k++; end
        while (rows !== r && k < 64) begin @(negedge clk); k++; end
        check(name, rows, r);
    endtask

    task automatic wait_valid(input logic v, input int budget, input string name);
        int k = 0;
        while (key_valid !== v && k < budget) begin @(negedge clk); k++; end
        check(name, key_valid, v);
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            check("rows_onehot", $countones(rows), 1);
            if (key_valid !== 1'b1) check("idle_code_zero", {key_rows, key_cols}, 8'h00);
            if (key_new === 1'b1) begin
                if (prev_valid !== 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_key_new", key_new, 1'b0);
                    end else begin
                        mon_k = exp_q.pop_front();
                        check("sb_key_rows", key_rows, mon_k.r);
                        check("sb_key_cols", key_cols, mon_k.c);
                        check("sb_key_valid", key_valid, 1'b1);
                    end
                end else begin
`ifdef KEYSCAN_AUTOREPEAT_EN
                    check("repeat_gap", ecnt - last_new, SCAN_DIV * REPEAT_DIV);
`else
                    check("repeat_key_new", key_new, 1'b0);
`endif
                end
                last_new = ecnt;
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        row_seq[0] = 4'b0001; row_seq[1] = 4'b0010;
        row_seq[2] = 4'b0100; row_seq[3] = 4'b1000;
        vecs[0] = '{4'b0001, 4'b0001, 1'b1};
        vecs[1] = '{4'b1000, 4'b1000, 1'b1};
        vecs[2] = '{4'b0010, 4'b0100, 1'b1};
        vecs[3] = '{4'b0100, 4'b0011, 1'b0};
        vecs[4] = '{4'b1000, 4'b0101, 1'b0};
        vecs[5] = '{4'b0001, 4'b1000, 1'b1};

        reset   = 1'b1;
        kp_down = 1'b0;
        kp_row  = 4'b0001;
        kp_col  = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_rows", rows, 4'b0001);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_new", key_new, 1'b0);
        check("reset_key_rows", key_rows, 4'b0000);
        check("reset_key_cols", key_cols, 4'b0000);
        reset = 1'b0;

        // Idle scan: each row held SCAN_DIV cycles, wrapping
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("scan_rows", rows, row_seq[(ecnt / SCAN_DIV) % 4]);
            check("scan_key_valid", key_valid, 1'b0);
        end

        // Single press with exact acceptance timing, then a long hold and release
        kp_row = 4'b0100; kp_col = 4'b0010; kp_down = 1'b1;
        exp_q.push_back({4'b0100, 4'b0010});
        wait_row_start(4'b0100, "press_row_reached");
        n = ecnt;
        repeat (11) @(negedge clk);
        check("press_early_valid", key_valid, 1'b0);
        check("press_early_new", key_new, 1'b0);
        @(negedge clk);
        check("press_new", key_new, 1'b1);
        check("press_valid", key_valid, 1'b1);
        check("press_key_rows", key_rows, 4'b0100);
        check("press_key_cols", key_cols, 4'b0010);
        @(negedge clk);
        check("press_new_pulse", key_new, 1'b0);
        check("press_valid_hold", key_valid, 1'b1);
        check("press_rows_frozen", rows, 4'b0100);
        repeat (80) @(negedge clk);
        while (ecnt % SCAN_DIV != 0) @(negedge clk);
        kp_down = 1'b0;
        n = ecnt;
        repeat (11) @(negedge clk);
        check("release_hold_valid", key_valid, 1'b1);
        @(negedge clk);
        check("release_valid", key_valid, 1'b0);
        check("release_next_row", rows, 4'b1000);
        check("release_cycles", ecnt - n, 12);

        // Bounce: one matching tick then a gap aborts the debounce
        kp_row = 4'b0100; kp_col = 4'b0010; kp_down = 1'b1;
        wait_row_start(4'b0100, "bounce_row_reached");
        repeat (5) @(negedge clk);
        kp_down = 1'b0;
        repeat (3) @(negedge clk);
        check("bounce_rows_resume", rows, 4'b1000);
        check("bounce_no_valid", key_valid, 1'b0);
        exp_q.push_back({4'b0100, 4'b0010});
        kp_down = 1'b1;
        wait_valid(1'b1, 100, "bounce_accept");
        check("bounce_key_rows", key_rows, 4'b0100);
        kp_down = 1'b0;
        wait_valid(1'b0, 100, "bounce_release");

        // Two columns in one row: no capture, scan keeps moving
        kp_row = 4'b0100; kp_col = 4'b0011; kp_down = 1'b1;
        wait_row_start(4'b0100, "multi_row_reached");
        repeat (4) @(negedge clk);
        check("multi_rows_advance", rows, 4'b1000);
        check("multi_no_valid", key_valid, 1'b0);
        kp_down = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            kp_row = vecs[i].row; kp_col = vecs[i].col; kp_down = 1'b1;
            if (vecs[i].accept) begin
                exp_q.push_back({vecs[i].row, vecs[i].col});
                wait_valid(1'b1, 100, "vec_accept");
                check("vec_key_rows", key_rows, vecs[i].row);
                check("vec_key_cols", key_cols, vecs[i].col);
                repeat (10) @(negedge clk);
                kp_down = 1'b0;
                wait_valid(1'b0, 100, "vec_release");
            end else begin
                repeat (40) @(negedge clk);
                check("vec_reject", key_valid, 1'b0);
                kp_down = 1'b0;
            end
            repeat (8) @(negedge clk);
        end

        // Reset in the middle of debounce
        kp_row = 4'b0100; kp_col = 4'b0010; kp_down = 1'b1;
        wait_row_start(4'b0100, "rstdb_row_reached");
        repeat (5) @(negedge clk);
        check("rstdb_pre_valid", key_valid, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rstdb_rows", rows, 4'b0001);
        check("rstdb_valid", key_valid, 1'b0);
        check("rstdb_new", key_new, 1'b0);
        kp_down = 1'b0;
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // Reset while a key is held
        kp_row = 4'b0010; kp_col = 4'b0100; kp_down = 1'b1;
        exp_q.push_back({4'b0010, 4'b0100});
        wait_valid(1'b1, 100, "rsthd_accept");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        kp_down = 1'b0;
        @(negedge clk);
        check("rsthd_rows", rows, 4'b0001);
        check("rsthd_valid", key_valid, 1'b0);
        check("rsthd_new", key_new, 1'b0);
        check("rsthd_code", {key_rows, key_cols}, 8'h00);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rsthd_idle_valid", key_valid, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab3_keyscan.md
Name: lab3_keyscan

Overview:
Keypad scan initiator for the lab 3 4x4 matrix.
- Drives a one-hot row strobe and samples the column lines.
- Debounces a single-key press and holds the {cols, rows} code for the lab 3 button-press decoder.
- Emits a one-cycle press pulse per accepted keystroke.
- Sits between the FPGA keypad pins and the decoder/display logic.

Parameters:
SCAN_DIV, 4096, clk cycles per row dwell and per debounce sample tick (>=2)
DEBOUNCE_CNT, 8, consecutive matching sample ticks needed to accept a press or a release (>=2)
REPEAT_DIV, 64, sample ticks between repeat pulses (used only with KEYSCAN_AUTOREPEAT_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cols  input  4  raw column lines, active-high, asynchronous to clk
rows  output  4  one-hot row strobe driven to the keypad
key_cols  output  4  accepted column code; 0 when key_valid=0
key_rows  output  4  accepted row code; 0 when key_valid=0
key_valid  output  1  high while an accepted key is held
key_new  output  1  one-cycle pulse per accepted press

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Input sync: cols pass through a 2-flop synchronizer, giving 2 cycles of latency. All decisions use the synced value scols.
- Tick counter: div_cnt counts 0..SCAN_DIV-1 and wraps. It runs free in every state. tick = (div_cnt==SCAN_DIV-1).
- Reset values: rows=0001, div_cnt=0, state=SCAN, debounce count=0, key_cols=0, key_rows=0, key_valid=0, key_new=0.
- SCAN state, on tick:
  - scols==0: advance rows (0001->0010->0100->1000->0001, wraps).
  - scols has more than one bit set: treat as an invalid multi-press; advance rows.
  - scols is exactly one-hot: capture cap_cols=scols and cap_rows=rows, set cnt=1, go to DEBOUNCE. rows freezes.
- DEBOUNCE state, on tick:
  - scols==cap_cols: cnt++. When cnt reaches DEBOUNCE_CNT, go to HELD. On the next cycle: key_valid=1, key_cols=cap_cols, key_rows=cap_rows, key_new=1 for exactly one cycle.
  - Otherwise: cnt=0, return to SCAN, advance rows.
- HELD state: rows stays frozen on cap_rows. On tick:
  - (scols & cap_cols)==0: cnt++.
  - Otherwise: cnt=0. Extra keys in the same row are ignored while the captured bit stays high.
  - When cnt reaches DEBOUNCE_CNT: go to SCAN, advance rows. On the next cycle: key_valid=0, key_cols=0, key_rows=0.
- Per-keystroke guarantee: key_new never asserts twice for one keystroke. A new press is accepted only after release has been debounced.
- Reset: reset in any state, mid-debounce or mid-hold, returns all state and outputs to their reset values on the next edge. No key_new is emitted.
- Widths: div_cnt is $clog2(SCAN_DIV) bits. cnt is $clog2(DEBOUNCE_CNT+1) bits and saturates; it never wraps.
- Registering: outputs come from flops. Nothing is combinational from cols.

Optional Feature:
KEYSCAN_AUTOREPEAT_EN
- Defined: while in HELD with the captured bit still high, key_new pulses once every REPEAT_DIV ticks after the initial press. The repeat count resets on release.
- Undefined: exactly one key_new per keystroke. REPEAT_DIV is unused and no repeat counter is synthesized.

Decomposition:
- Shared package lab3_pkg:
  - scan state enum {SCAN, DEBOUNCE, HELD}
  - ROW_INIT=4'b0001
  - NUM_ROWS=4 and NUM_COLS=4
- One sub-module, lab3_sync: a parameterized-width 2-flop synchronizer, instantiated on cols.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3.
1. Reset, no press -> rows cycles 0001,0010,0100,1000,0001, each held 4 cycles. Outputs stay 0.
2. Hold cols=0010 while rows=0100 is strobed -> after 3 matching ticks: key_rows=0100, key_cols=0010, key_valid=1, a single key_new. Decoder yields num=5.
3. Bounce: cols=0010 for 1 tick, then 0000, then 0010 -> no key_new until 3 consecutive matching ticks. rows resumes scanning after the mismatch.
4. Press held for 100 cycles, then released -> one key_new. key_valid drops 3 ticks after release and scanning resumes at the next row.
5. cols=0011 during a scan tick -> no capture, rows advances, no output change.
6. reset asserted mid-DEBOUNCE and mid-HELD -> next cycle: rows=0001, key_valid=0, key_new=0.
   With KEYSCAN_AUTOREPEAT_EN and REPEAT_DIV=2: holding the key gives key_new every 8 cycles after the first.
